bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-requester round-robin arbiter placed directly upstream of busctl.
- Accepts single-beat read/write requests from two masters: port 0 is the CPU domain, port 1 is a second master (DMA/debug).
- Serialises them onto busctl's bus_we / bus_addr / bus_data_in inputs.
- Captures read data from busctl's bus_data_out after a fixed latency and returns it to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 16, width of request and bus addresses.
- DATA_WIDTH, 8, width of write/read data; matches the busctl data path.
- RD_LATENCY, 1, cycles from the ISSUE cycle to valid bus_rdata; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has a transaction.
- req0_we  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  transaction address.
- req0_wdata  input  DATA_WIDTH  write data.
- req0_ready  output  1  transaction accepted this cycle.
- req0_rvalid  output  1  one-cycle pulse; req0_rdata valid.
- req0_rdata  output  DATA_WIDTH  read data, held until the next req0 read completes.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as req0, for requester 1.
- bus_we  output  1  write strobe to busctl.
- bus_addr  output  ADDR_WIDTH  address to busctl.
- bus_wdata  output  DATA_WIDTH  write data; connects to busctl bus_data_in.
- bus_rdata  input  DATA_WIDTH  read data; comes from busctl bus_data_out.

Behaviour:
- Reset (reset == 0 sampled at a clock edge):
  - State = IDLE; priority pointer favours req0.
  - All outputs are 0: bus_we, bus_addr, bus_wdata, both ready, both rvalid, both rdata.
  - Reset wins over every other event.
- FSM has three states: IDLE, ISSUE, WAIT.
- IDLE:
  - reqN_ready is combinational and is asserted for exactly one requester, and only when that requester's valid is high.
  - Handshake completes when valid && ready.
  - Selection when both valids are high: the requester indicated by the pointer wins. A lone valid always wins.
  - On handshake: latch we, addr, wdata and owner id; flip the pointer to favour the other requester; go to ISSUE.
  - With no valid: stay in IDLE, ready = 0.
- ISSUE (exactly one cycle):
  - bus_addr and bus_wdata are driven from the latched registers.
  - bus_we = latched we.
  - Write: go to IDLE; no rvalid is generated.
  - Read: load the latency counter with RD_LATENCY - 1 and go to WAIT.
- WAIT:
  - bus_we = 0; bus_addr and bus_wdata hold their values.
  - Counter decrements each cycle.
  - When the counter is 0 (i.e., RD_LATENCY cycles after ISSUE): register bus_rdata into the owner's rdata and pulse the owner's rvalid high for the following cycle, then go to IDLE.
- Timing of a read return: the rvalid pulse coincides with the first IDLE cycle, so a new request can be accepted in the same cycle the previous read's rvalid is high.
- Outside ISSUE, bus_we is always 0. bus_addr and bus_wdata hold their last issued values; they do not return to 0.
- The non-owner's rvalid and rdata are never disturbed.
- Requester rules:
  - valid and all request fields must be held stable until ready.
  - A requester may drop valid before ready; this is not an error, and nothing is latched.
  - ready is never asserted outside IDLE.
- Throughput:
  - Write: 2 cycles per transaction (IDLE + ISSUE).
  - Read: 2 + RD_LATENCY cycles.
  - Under continuous contention, grants strictly alternate 0, 1, 0, 1...
- Counter width: 4 bits, sufficient for RD_LATENCY ≤ 15.

Test Plan:
- Reset, then idle: hold reset = 0 for 2 cycles with both valids high → all outputs 0, no ready. Release reset → req0 gets ready in the first IDLE cycle.
- Single write: req0 write, addr 0x1234, wdata 0xA5 → ready the same cycle. Next cycle: bus_we = 1, bus_addr = 0x1234, bus_wdata = 0xA5. Following cycle: bus_we = 0, no rvalid.
- Single read, RD_LATENCY = 1: req1 read, addr 0x0040; the bench drives bus_rdata = 0x3C one cycle after ISSUE → req1_rvalid pulses 1 cycle with req1_rdata = 0x3C. req0_rvalid stays 0 and req0_rdata is unchanged.
- Contention: both valids held high with back-to-back writes → grant order 0, 1, 0, 1; every ISSUE cycle is separated by exactly one IDLE cycle.
- Latency sweep with RD_LATENCY = 3: a read returns rvalid exactly 4 cycles after ISSUE. bus_rdata changes before the sample point are ignored; the sampled value is 0x77.
- Reset mid-read: assert reset in WAIT → next cycle state is IDLE, no rvalid, bus_we = 0, rdata = 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/response signals of the two-master round-robin arbiter and its
// single-beat bus port. The arbiter takes the slave view; requesters and the bus model take the master view.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req0_rvalid;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  req1_rvalid;
    logic [DATA_WIDTH-1:0] req1_rdata;

    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output bus_we, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  bus_we, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter serialising single-beat reads/writes onto
// busctl, returning read data to the issuing requester after RD_LATENCY cycles.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  bus_we_q, bus_we_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  grant0_s;
    logic                  grant1_s;

    // Next-state, grant selection and datapath loads.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        bus_we_d  = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        grant0_s  = 1'b0;
        grant1_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ptr_q == 0 favours requester 0; a lone valid always wins.
                grant0_s = reset & bus.req0_valid & (~bus.req1_valid | ~ptr_q);
                grant1_s = reset & bus.req1_valid & (~bus.req0_valid | ptr_q);
                if (grant0_s) begin
                    owner_d  = 1'b0;
                    we_d     = bus.req0_we;
                    addr_d   = bus.req0_addr;
                    wdata_d  = bus.req0_wdata;
                    bus_we_d = bus.req0_we;
                    ptr_d    = 1'b1;
                    state_d  = S_ISSUE;
                end else if (grant1_s) begin
                    owner_d  = 1'b1;
                    we_d     = bus.req1_we;
                    addr_d   = bus.req1_addr;
                    wdata_d  = bus.req1_wdata;
                    bus_we_d = bus.req1_we;
                    ptr_d    = 1'b0;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        rdata1_d  = bus.bus_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = bus.bus_rdata;
                        rvalid0_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            cnt_q     <= 4'd0;
            bus_we_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= {DATA_WIDTH{1'b0}};
            rdata1_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            bus_we_q  <= bus_we_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Latched address/data only change on a handshake, so they hold the last issued values.
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wdata   = wdata_q;
    assign bus.req0_ready  = grant0_s;
    assign bus.req1_ready  = grant1_s;
    assign bus.req0_rvalid = rvalid0_q;
    assign bus.req1_rvalid = rvalid1_q;
    assign bus.req0_rdata  = rdata0_q;
    assign bus.req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=3, all expected values written out by hand.
module tb_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();
    bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif3 ();

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0;
        bif.req0_valid = 1'b1; bif.req0_we = 1'b1; bif.req0_addr = 16'h1234; bif.req0_wdata = 8'hA5;
        bif.req1_valid = 1'b1; bif.req1_we = 1'b0; bif.req1_addr = 16'h0040; bif.req1_wdata = 8'h00;
        bif.bus_rdata  = 8'h00;
        bif3.req0_valid = 1'b0; bif3.req0_we = 1'b0; bif3.req0_addr = 16'h0000; bif3.req0_wdata = 8'h00;
        bif3.req1_valid = 1'b0; bif3.req1_we = 1'b0; bif3.req1_addr = 16'h0000; bif3.req1_wdata = 8'h00;
        bif3.bus_rdata  = 8'h00;

        // Reset held for two cycles with both valids high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_ready0", bif.req0_ready, 1'b0);
            chk("rst_ready1", bif.req1_ready, 1'b0);
            chk("rst_bus_we", bif.bus_we, 1'b0);
            chk("rst_bus_addr", bif.bus_addr, 16'h0000);
            chk("rst_bus_wdata", bif.bus_wdata, 8'h00);
            chk("rst_rvalid0", bif.req0_rvalid, 1'b0);
            chk("rst_rvalid1", bif.req1_rvalid, 1'b0);
            chk("rst_rdata0", bif.req0_rdata, 8'h00);
            chk("rst_rdata1", bif.req1_rdata, 8'h00);
        end

        // Release: req0 wins first IDLE cycle; this is the single write
        reset = 1'b1;
        #1;
        chk("rel_ready0", bif.req0_ready, 1'b1);
        chk("rel_ready1", bif.req1_ready, 1'b0);
        step();
        bif.req0_valid = 1'b0;
        #1;
        chk("wr_issue_we", bif.bus_we, 1'b1);
        chk("wr_issue_addr", bif.bus_addr, 16'h1234);
        chk("wr_issue_wdata", bif.bus_wdata, 8'hA5);
        chk("wr_issue_ready1", bif.req1_ready, 1'b0);
        step();
        chk("wr_after_we", bif.bus_we, 1'b0);
        chk("wr_after_rvalid0", bif.req0_rvalid, 1'b0);
        chk("wr_after_addr_hold", bif.bus_addr, 16'h1234);

        // Single read by req1 with RD_LATENCY = 1
        chk("rd_ready1", bif.req1_ready, 1'b1);
        step();
        bif.req1_valid = 1'b0;
        bif.bus_rdata  = 8'h11;
        #1;
        chk("rd_issue_we", bif.bus_we, 1'b0);
        chk("rd_issue_addr", bif.bus_addr, 16'h0040);
        step();
        bif.bus_rdata = 8'h3C;
        chk("rd_wait_rvalid1", bif.req1_rvalid, 1'b0);
        step();
        bif.bus_rdata = 8'h99;
        chk("rd_rvalid1", bif.req1_rvalid, 1'b1);
        chk("rd_rdata1", bif.req1_rdata, 8'h3C);
        chk("rd_rvalid0", bif.req0_rvalid, 1'b0);
        chk("rd_rdata0", bif.req0_rdata, 8'h00);
        step();
        chk("rd_pulse_end", bif.req1_rvalid, 1'b0);
        chk("rd_rdata1_hold", bif.req1_rdata, 8'h3C);

        // Continuous contention with writes: grants alternate 0,1,0,1
        bif.req0_valid = 1'b1; bif.req0_we = 1'b1; bif.req0_addr = 16'h1000; bif.req0_wdata = 8'h01;
        bif.req1_valid = 1'b1; bif.req1_we = 1'b1; bif.req1_addr = 16'h2000; bif.req1_wdata = 8'h02;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("cont_ready0", bif.req0_ready, (g % 2 == 0) ? 1'b1 : 1'b0);
            chk("cont_ready1", bif.req1_ready, (g % 2 == 1) ? 1'b1 : 1'b0);
            step();
            chk("cont_issue_we", bif.bus_we, 1'b1);
            chk("cont_issue_addr", bif.bus_addr, (g % 2 == 0) ? 16'h1000 : 16'h2000);
            chk("cont_issue_wdata", bif.bus_wdata, (g % 2 == 0) ? 8'h01 : 8'h02);
            chk("cont_issue_noready", bif.req0_ready | bif.req1_ready, 1'b0);
            step();
        end
        bif.req0_valid = 1'b0;
        bif.req1_valid = 1'b0;
        #1;
        chk("cont_idle_we", bif.bus_we, 1'b0);

        // RD_LATENCY = 3: rvalid four cycles after ISSUE, value 0x77
        bif3.req0_valid = 1'b1; bif3.req0_we = 1'b0; bif3.req0_addr = 16'h0ABC;
        #1;
        chk("lat_ready0", bif3.req0_ready, 1'b1);
        step();
        bif3.req0_valid = 1'b0;
        bif3.bus_rdata  = 8'h55;
        chk("lat_issue_addr", bif3.bus_addr, 16'h0ABC);
        chk("lat_issue_we", bif3.bus_we, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("lat_early_rvalid0", bif3.req0_rvalid, 1'b0);
            bif3.bus_rdata = (k == 1) ? 8'h11 : ((k == 2) ? 8'h22 : 8'h77);
        end
        step();
        bif3.bus_rdata = 8'h88;
        chk("lat_rvalid0", bif3.req0_rvalid, 1'b1);
        chk("lat_rdata0", bif3.req0_rdata, 8'h77);
        chk("lat_rvalid1", bif3.req1_rvalid, 1'b0);

        // Reset asserted while a read is in WAIT
        bif3.req1_valid = 1'b1; bif3.req1_we = 1'b0; bif3.req1_addr = 16'h0BEE;
        #1;
        chk("mid_ready1", bif3.req1_ready, 1'b1);
        step();
        bif3.req1_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("mid_rvalid0", bif3.req0_rvalid, 1'b0);
        chk("mid_rvalid1", bif3.req1_rvalid, 1'b0);
        chk("mid_bus_we", bif3.bus_we, 1'b0);
        chk("mid_rdata0", bif3.req0_rdata, 8'h00);
        chk("mid_rdata1", bif3.req1_rdata, 8'h00);
        chk("mid_bus_addr", bif3.bus_addr, 16'h0000);
        reset = 1'b1;
        step();
        chk("mid_after_rvalid1", bif3.req1_rvalid, 1'b0);
        bif3.req0_valid = 1'b1;
        #1;
        chk("mid_idle_ready0", bif3.req0_ready, 1'b1);
        chk("mid_idle_ready1", bif3.req1_ready, 1'b0);
        bif3.req0_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
